// File: rtl/rv32_branch_resolve_ctrl.sv
// rv32_branch_resolve_ctrl
// Resolves one branch/JAL/JALR at a time for the RV32IM core: latches the op
// from decode, drives the external condition evaluator, computes target and
// link address, redirects fetch over valid/ready and holds a pipeline flush.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          decode handshake (ready only while idle)
//   req_kind/funct3/pc/imm/rs1/rs2  control-flow op payload
//   bu_branch_en/funct3/rs1/rs2  registered request to the condition evaluator
//   bu_taken                     evaluator result, sampled during EVAL
//   redir_valid/ready/pc         redirect handshake to fetch
//   flush_o                      squash younger stages for FLUSH_CYCLES cycles
//   done_o, link_o, misalign_o   one-cycle retirement pulse with link / misalign
//   taken_cnt                    number of completed redirects (wrapping)
module rv32_branch_resolve_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_kind,
   input  logic [2:0]       req_funct3,
   input  logic [XLEN-1:0]  req_pc,
   input  logic [XLEN-1:0]  req_imm,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   output logic             bu_branch_en,
   output logic [2:0]       bu_funct3,
   output logic [XLEN-1:0]  bu_rs1,
   output logic [XLEN-1:0]  bu_rs2,
   input  logic             bu_taken,
   output logic             redir_valid,
   input  logic             redir_ready,
   output logic [XLEN-1:0]  redir_pc,
   output logic             flush_o,
   output logic             done_o,
   output logic [XLEN-1:0]  link_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [1:0] KIND_BR   = 2'b00;
   localparam logic [1:0] KIND_JAL  = 2'b01;
   localparam logic [1:0] KIND_JALR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      REDIR = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t          state;
   logic [1:0]      kind_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] imm_q;
   logic [FC_W-1:0] flush_cnt;

   logic            take_c;
   logic            is_jump_c;
   logic [XLEN-1:0] tgt_c;
   logic [XLEN-1:0] link_c;

   // Decision inputs for EVAL; bu_rs1 doubles as the latched rs1 for JALR.
   always_comb begin
      take_c    = 1'b0;
      is_jump_c = (kind_q == KIND_JAL) || (kind_q == KIND_JALR);
      tgt_c     = pc_q + imm_q;
      link_c    = pc_q + XLEN'(4);
      case (kind_q)
         KIND_BR:   take_c = bu_taken;
         KIND_JAL:  take_c = 1'b1;
         KIND_JALR: begin
            take_c = 1'b1;
            tgt_c  = (bu_rs1 + imm_q) & ~XLEN'(1);
         end
         default:   take_c = 1'b0;
      endcase
   end

   // Control FSM with registered outputs; retirement outputs default to a pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         kind_q       <= '0;
         pc_q         <= '0;
         imm_q        <= '0;
         flush_cnt    <= '0;
         bu_branch_en <= 1'b0;
         bu_funct3    <= '0;
         bu_rs1       <= '0;
         bu_rs2       <= '0;
         redir_valid  <= 1'b0;
         redir_pc     <= '0;
         flush_o      <= 1'b0;
         done_o       <= 1'b0;
         link_o       <= '0;
         misalign_o   <= 1'b0;
         taken_cnt    <= '0;
      end else begin
         done_o     <= 1'b0;
         misalign_o <= 1'b0;
         link_o     <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state        <= EVAL;
                  req_ready    <= 1'b0;
                  kind_q       <= req_kind;
                  pc_q         <= req_pc;
                  imm_q        <= req_imm;
                  bu_funct3    <= req_funct3;
                  bu_rs1       <= req_rs1;
                  bu_rs2       <= req_rs2;
                  bu_branch_en <= (req_kind == KIND_BR);
               end
            end
            EVAL: begin
               bu_branch_en <= 1'b0;
               // Not-taken and misaligned-taken both retire here without a redirect.
               if (!take_c || (tgt_c[1:0] != 2'b00)) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  done_o     <= 1'b1;
                  misalign_o <= take_c;
                  link_o     <= is_jump_c ? link_c : '0;
               end else begin
                  state       <= REDIR;
                  redir_valid <= 1'b1;
                  redir_pc    <= tgt_c;
               end
            end
            REDIR: begin
               if (redir_ready) begin
                  state       <= FLUSH;
                  redir_valid <= 1'b0;
                  flush_o     <= 1'b1;
                  flush_cnt   <= FC_W'(FLUSH_CYCLES - 1);
                  done_o      <= 1'b1;
                  link_o      <= is_jump_c ? link_c : '0;
                  taken_cnt   <= taken_cnt + CNT_W'(1);
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state     <= IDLE;
                  flush_o   <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - FC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_branch_resolve_ctrl.sv
// Bench for rv32_branch_resolve_ctrl: scoreboard of expected retirements
// plus cycle-level checks, and a CNT_W=4 instance for counter wrap.
module tb_rv32_branch_resolve_ctrl;

   typedef struct packed {
      logic        redir;
      logic [31:0] pc;
      logic [31:0] link;
      logic        mis;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_kind = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
   logic        bu_branch_en;
   logic [2:0]  bu_funct3;
   logic [31:0] bu_rs1, bu_rs2;
   logic        bu_taken;
   logic        redir_valid;
   logic        redir_ready = 1'b1;
   logic [31:0] redir_pc;
   logic        flush_o, done_o, misalign_o;
   logic [31:0] link_o;
   logic [15:0] taken_cnt;

   logic        req_valid2 = 1'b0;
   logic        req_ready2;
   logic        bu_branch_en2;
   logic [2:0]  bu_funct3_2;
   logic [31:0] bu_rs1_2, bu_rs2_2;
   logic        bu_taken2 = 1'b0;
   logic        redir_valid2;
   logic        redir_ready2 = 1'b1;
   logic [31:0] redir_pc2;
   logic        flush2, done2, mis2;
   logic [31:0] link2;
   logic [3:0]  taken_cnt2;

   int   compared = 0;
   int   mismatched = 0;
   res_t exp_q[$];
   res_t obs_q[$];
   logic        cur_redir = 1'b0;
   logic [31:0] cur_pc = '0;
   int   flush_run = 0;
   int   last_flush = 0;

   always #5 clk = ~clk;

   rv32_branch_resolve_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_funct3(req_funct3), .req_pc(req_pc),
      .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .bu_branch_en(bu_branch_en), .bu_funct3(bu_funct3), .bu_rs1(bu_rs1),
      .bu_rs2(bu_rs2), .bu_taken(bu_taken), .redir_valid(redir_valid),
      .redir_ready(redir_ready), .redir_pc(redir_pc), .flush_o(flush_o),
      .done_o(done_o), .link_o(link_o), .misalign_o(misalign_o),
      .taken_cnt(taken_cnt)
   );

   rv32_branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_kind(req_kind), .req_funct3(req_funct3), .req_pc(req_pc),
      .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .bu_branch_en(bu_branch_en2), .bu_funct3(bu_funct3_2), .bu_rs1(bu_rs1_2),
      .bu_rs2(bu_rs2_2), .bu_taken(bu_taken2), .redir_valid(redir_valid2),
      .redir_ready(redir_ready2), .redir_pc(redir_pc2), .flush_o(flush2),
      .done_o(done2), .link_o(link2), .misalign_o(mis2),
      .taken_cnt(taken_cnt2)
   );

   // Condition evaluator model; only answers while the controller enables it.
   always_comb begin
      case (bu_funct3)
         3'b000:  bu_taken = (bu_rs1 == bu_rs2);
         3'b001:  bu_taken = (bu_rs1 != bu_rs2);
         3'b100:  bu_taken = ($signed(bu_rs1) <  $signed(bu_rs2));
         3'b101:  bu_taken = ($signed(bu_rs1) >= $signed(bu_rs2));
         3'b110:  bu_taken = (bu_rs1 <  bu_rs2);
         3'b111:  bu_taken = (bu_rs1 >= bu_rs2);
         default: bu_taken = 1'b0;
      endcase
      bu_taken = bu_taken & bu_branch_en;
   end

   // Retirement monitor: records redirect handshakes, done pulses and flush length.
   always @(negedge clk) begin
      if (rst) begin
         cur_redir = 1'b0;
         flush_run = 0;
      end else begin
         if (redir_valid && redir_ready) begin
            cur_redir = 1'b1;
            cur_pc    = redir_pc;
         end
         if (done_o) begin
            obs_q.push_back({cur_redir, (cur_redir ? cur_pc : 32'h0), link_o, misalign_o});
            cur_redir = 1'b0;
         end
         if (flush_o) flush_run++;
         else if (flush_run > 0) begin
            last_flush = flush_run;
            flush_run  = 0;
         end
      end
   end

   function automatic res_t mk(input logic r, input logic [31:0] pc,
                               input logic [31:0] link, input logic mis);
      mk = {r, pc, link, mis};
   endfunction

   // Presents an op and holds req_valid until it is accepted (bounded).
   task automatic issue(input logic [1:0] k, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        output bit ok);
      int n = 0;
      req_kind = k; req_funct3 = f3; req_pc = pc; req_imm = imm;
      req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
      while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
      ok = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
      ok = req_ready;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++; $display("FAIL reset_ready: got %0b want 1", req_ready);
      end
      compared++;
      if ({redir_valid, flush_o, done_o, misalign_o, bu_branch_en} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got %b want 00000",
                  {redir_valid, flush_o, done_o, misalign_o, bu_branch_en});
      end
      compared++;
      if ({redir_pc, link_o, bu_rs1, bu_rs2} !== 128'h0) begin
         mismatched++;
         $display("FAIL reset_data: got pc=%h link=%h rs1=%h rs2=%h want 0",
                  redir_pc, link_o, bu_rs1, bu_rs2);
      end
      compared++;
      if (taken_cnt !== 16'h0 || taken_cnt2 !== 4'h0) begin
         mismatched++;
         $display("FAIL reset_cnt: got %h/%h want 0/0", taken_cnt, taken_cnt2);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      compared++;
      if (req_ready !== 1'b1 || done_o !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle: got ready=%0b done=%0b want 1/0", req_ready, done_o);
      end
   endtask

   task automatic test_beq();
      bit ok;
      res_t e, o;
      exp_q.push_back(mk(1'b1, 32'h120, 32'h0, 1'b0));
      issue(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL beq_accept: got no accept want accept"); end
      compared++;
      if ({req_ready, bu_branch_en} !== 2'b01) begin
         mismatched++;
         $display("FAIL beq_eval: got ready/en=%b want 01", {req_ready, bu_branch_en});
      end
      @(posedge clk); #1;
      compared++;
      if ({redir_valid, flush_o, done_o} !== 3'b100 || redir_pc !== 32'h120) begin
         mismatched++;
         $display("FAIL beq_redir: got v/f/d=%b pc=%h want 100 pc=00000120",
                  {redir_valid, flush_o, done_o}, redir_pc);
      end
      @(posedge clk); #1;
      compared++;
      if ({redir_valid, flush_o, done_o, req_ready} !== 4'b0110 || taken_cnt !== 16'd1) begin
         mismatched++;
         $display("FAIL beq_flush1: got v/f/d/r=%b cnt=%0d want 0110 cnt=1",
                  {redir_valid, flush_o, done_o, req_ready}, taken_cnt);
      end
      @(posedge clk); #1;
      compared++;
      if ({flush_o, done_o, req_ready} !== 3'b100) begin
         mismatched++;
         $display("FAIL beq_flush2: got f/d/r=%b want 100", {flush_o, done_o, req_ready});
      end
      @(posedge clk); #1;
      compared++;
      if ({flush_o, req_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL beq_idle: got f/r=%b want 01", {flush_o, req_ready});
      end
      @(posedge clk); #1;
      compared++;
      if (last_flush !== 2) begin
         mismatched++; $display("FAIL beq_flush_len: got %0d want 2", last_flush);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL beq_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL beq_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
   endtask

   task automatic test_blt_bltu();
      bit ok;
      res_t e, o;
      exp_q.push_back(mk(1'b1, 32'h210, 32'h0, 1'b0));
      issue(2'b00, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1, ok);
      exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0));
      issue(2'b00, 3'b110, 32'h220, 32'h10, 32'hFFFF_FFFF, 32'h1, ok);
      compared++;
      if (!ok || done_o !== 1'b0) begin
         mismatched++; $display("FAIL bltu_early: got ok=%0b done=%0b want 1/0", ok, done_o);
      end
      @(posedge clk); #1;
      compared++;
      if ({done_o, req_ready, redir_valid, misalign_o} !== 4'b1100) begin
         mismatched++;
         $display("FAIL bltu_done: got d/r/v/m=%b want 1100",
                  {done_o, req_ready, redir_valid, misalign_o});
      end
      wait_idle(ok);
      compared++;
      if (taken_cnt !== 16'd2) begin
         mismatched++; $display("FAIL blt_cnt: got %0d want 2", taken_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL blt_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL blt_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
   endtask

   task automatic test_jumps();
      bit ok;
      res_t e, o;
      // (0x1001+4)&~1 exercises the JALR low-bit clear.
      exp_q.push_back(mk(1'b1, 32'h1004, 32'h44, 1'b0));
      issue(2'b10, 3'b000, 32'h40, 32'h4, 32'h1001, 32'h0, ok);
      // 0x1002 is not word aligned, so it retires as a misalign.
      exp_q.push_back(mk(1'b0, 32'h0, 32'h44, 1'b1));
      issue(2'b10, 3'b000, 32'h40, 32'h2, 32'h1001, 32'h0, ok);
      exp_q.push_back(mk(1'b0, 32'h0, 32'h44, 1'b1));
      issue(2'b01, 3'b000, 32'h40, 32'h6, 32'h0, 32'h0, ok);
      exp_q.push_back(mk(1'b1, 32'h78, 32'h84, 1'b0));
      issue(2'b01, 3'b000, 32'h80, 32'hFFFF_FFF8, 32'h0, 32'h0, ok);
      // Illegal kind with an operand pair that would satisfy BEQ.
      exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0));
      issue(2'b11, 3'b000, 32'h10, 32'h10, 32'h9, 32'h9, ok);
      exp_q.push_back(mk(1'b1, 32'h10, 32'h504, 1'b0));
      issue(2'b10, 3'b000, 32'h500, 32'h20, 32'hFFFF_FFF0, 32'h0, ok);
      wait_idle(ok);
      compared++;
      if (!ok || taken_cnt !== 16'd5) begin
         mismatched++; $display("FAIL jump_cnt: got %0d want 5", taken_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL jump_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL jump_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      res_t e, o;
      redir_ready = 1'b0;
      exp_q.push_back(mk(1'b1, 32'h340, 32'h0, 1'b0));
      issue(2'b00, 3'b101, 32'h300, 32'h40, 32'd3, 32'd3, ok);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         compared++;
         if ({redir_valid, flush_o, done_o} !== 3'b100 || redir_pc !== 32'h340) begin
            mismatched++;
            $display("FAIL stall_%0d: got v/f/d=%b pc=%h want 100 pc=00000340",
                     i, {redir_valid, flush_o, done_o}, redir_pc);
         end
         @(posedge clk); #1;
      end
      redir_ready = 1'b1;
      @(posedge clk); #1;
      compared++;
      if ({redir_valid, flush_o, done_o} !== 3'b011) begin
         mismatched++;
         $display("FAIL stall_release: got v/f/d=%b want 011", {redir_valid, flush_o, done_o});
      end
      wait_idle(ok);
      compared++;
      if (!ok || taken_cnt !== 16'd6) begin
         mismatched++; $display("FAIL stall_cnt: got %0d want 6", taken_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL stall_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL stall_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      res_t e, o;
      exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0));
      issue(2'b00, 3'b001, 32'h600, 32'h8, 32'd7, 32'd7, ok);
      exp_q.push_back(mk(1'b1, 32'h704, 32'h0, 1'b0));
      issue(2'b00, 3'b111, 32'h604, 32'h100, 32'd2, 32'd1, ok);
      exp_q.push_back(mk(1'b1, 32'h1700, 32'h704, 1'b0));
      issue(2'b01, 3'b000, 32'h700, 32'h1000, 32'h0, 32'h0, ok);
      exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0));
      issue(2'b00, 3'b100, 32'h800, 32'h8, 32'h1, 32'hFFFF_FFFF, ok);
      wait_idle(ok);
      compared++;
      if (!ok || taken_cnt !== 16'd8) begin
         mismatched++; $display("FAIL b2b_cnt: got %0d want 8", taken_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL b2b_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL b2b_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
   endtask

   task automatic test_cnt_wrap();
      int n;
      for (int i = 0; i < 16; i++) begin
         req_kind = 2'b01; req_funct3 = 3'b000; req_pc = 32'h0; req_imm = 32'h8;
         req_valid2 = 1'b1;
         n = 0;
         while (!req_ready2 && n < 200) begin @(posedge clk); #1; n++; end
         @(posedge clk); #1;
         req_valid2 = 1'b0;
         n = 0;
         while (!req_ready2 && n < 200) begin @(posedge clk); #1; n++; end
         if (i == 14) begin
            compared++;
            if (taken_cnt2 !== 4'hF) begin
               mismatched++; $display("FAIL cnt_full: got %h want f", taken_cnt2);
            end
         end
      end
      compared++;
      if (taken_cnt2 !== 4'h0 || req_ready2 !== 1'b1) begin
         mismatched++;
         $display("FAIL cnt_wrap: got cnt=%h ready=%0b want 0/1", taken_cnt2, req_ready2);
      end
   endtask

   task automatic test_reset_flush();
      bit ok;
      int n = 0;
      res_t e, o;
      exp_q.push_back(mk(1'b1, 32'h900, 32'h0, 1'b0));
      issue(2'b00, 3'b000, 32'h8F0, 32'h10, 32'd1, 32'd1, ok);
      while (!(flush_o && !done_o) && n < 50) begin @(posedge clk); #1; n++; end
      compared++;
      if (n >= 50) begin mismatched++; $display("FAIL rf_reach: got no flush want flush"); end
      #1 rst = 1'b1;
      #1;
      compared++;
      if ({redir_valid, flush_o, done_o, misalign_o, req_ready} !== 5'b00001 ||
          taken_cnt !== 16'h0 || redir_pc !== 32'h0) begin
         mismatched++;
         $display("FAIL rf_async: got v/f/d/m/r=%b cnt=%0d pc=%h want 00001 0 0",
                  {redir_valid, flush_o, done_o, misalign_o, req_ready}, taken_cnt, redir_pc);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      redir_ready = 1'b0;
      issue(2'b01, 3'b000, 32'hA00, 32'h40, 32'h0, 32'h0, ok);
      @(posedge clk); #1;
      #1 rst = 1'b1;
      #1;
      compared++;
      if ({redir_valid, done_o, req_ready} !== 3'b001) begin
         mismatched++;
         $display("FAIL rr_async: got v/d/r=%b want 001", {redir_valid, done_o, req_ready});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      redir_ready = 1'b1;
      exp_q.push_back(mk(1'b1, 32'hB20, 32'h0, 1'b0));
      issue(2'b00, 3'b001, 32'hB00, 32'h20, 32'd1, 32'd2, ok);
      wait_idle(ok);
      compared++;
      if (!ok || taken_cnt !== 16'd1) begin
         mismatched++; $display("FAIL rf_after: got cnt=%0d want 1", taken_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++; $display("FAIL rf_sb: got nothing want pc=%h", e.pc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL rf_sb: got r=%0b pc=%h link=%h mis=%0b want r=%0b pc=%h link=%h mis=%0b",
                        o.redir, o.pc, o.link, o.mis, e.redir, e.pc, e.link, e.mis);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL rf_extra: got %0d extra retirements want 0", obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_blt_bltu();
      test_jumps();
      test_stall();
      test_back_to_back();
      test_cnt_wrap();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
